// File: rtl/travel_pkg.sv
// rtl/travel_pkg.sv - travel codes, station table, sprite size and FSM encoding for travel_animator
package travel_pkg;

  localparam int SPRITE_W = 4;
  localparam logic [3:0] PIX_LAST = 4'(SPRITE_W * SPRITE_W - 1);

  localparam logic [2:0] TRAVEL_NONE  = 3'b000;
  localparam logic [2:0] TRAVEL_S0_S1 = 3'b001;
  localparam logic [2:0] TRAVEL_S1_S2 = 3'b010;
  localparam logic [2:0] TRAVEL_S2_S3 = 3'b011;
  localparam logic [2:0] TRAVEL_S3_S4 = 3'b101;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } pos_t;

  localparam pos_t STATION_S0 = '{x: 8'd8,   y: 7'd56};
  localparam pos_t STATION_S1 = '{x: 8'd44,  y: 7'd56};
  localparam pos_t STATION_S2 = '{x: 8'd80,  y: 7'd56};
  localparam pos_t STATION_S3 = '{x: 8'd116, y: 7'd56};
  localparam pos_t STATION_S4 = '{x: 8'd148, y: 7'd100};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAW  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ERASE = 3'd3,
    ST_STEP  = 3'd4,
    ST_DONE  = 3'd5,
    ST_HOLD  = 3'd6
  } state_t;

  function automatic logic leg_valid(input logic [2:0] code);
    return (code == TRAVEL_S0_S1) || (code == TRAVEL_S1_S2) ||
           (code == TRAVEL_S2_S3) || (code == TRAVEL_S3_S4);
  endfunction

  function automatic pos_t leg_start(input logic [2:0] code);
    case (code)
      TRAVEL_S1_S2: return STATION_S1;
      TRAVEL_S2_S3: return STATION_S2;
      TRAVEL_S3_S4: return STATION_S3;
      default:      return STATION_S0;
    endcase
  endfunction

  function automatic pos_t leg_end(input logic [2:0] code);
    case (code)
      TRAVEL_S1_S2: return STATION_S2;
      TRAVEL_S2_S3: return STATION_S3;
      TRAVEL_S3_S4: return STATION_S4;
      default:      return STATION_S1;
    endcase
  endfunction

  // One pixel toward the target, never past it.
  function automatic logic [7:0] approach_x(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) return cur + 8'd1;
    if (cur > tgt) return cur - 8'd1;
    return cur;
  endfunction

  function automatic logic [6:0] approach_y(input logic [6:0] cur, input logic [6:0] tgt);
    if (cur < tgt) return cur + 7'd1;
    if (cur > tgt) return cur - 7'd1;
    return cur;
  endfunction

endpackage

// File: rtl/frame_ticker.sv
// rtl/frame_ticker.sv - frame-period down-counter; tc_o marks the last cycle of a frame wait
module frame_ticker #(
  parameter int unsigned FRAME_DIV = 833333
) (
  input  logic clock,
  input  logic resetn,
  input  logic load_i,
  output logic tc_o
);

  localparam logic [19:0] RELOAD = 20'(FRAME_DIV - 1);

  logic [19:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = RELOAD;
    end else if (count_q != '0) begin
      count_d = count_q - 20'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/travel_animator.sv
// rtl/travel_animator.sv - moves a 4x4 sprite between stations; TRAVEL_DIAGONAL_EN selects diagonal steps
module travel_animator
  import travel_pkg::*;
#(
  parameter int unsigned FRAME_DIV     = 833333,
  parameter logic [2:0]  SPRITE_COLOUR = 3'b110
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [2:0] travel,
  output logic       done_travel,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy
);

  state_t     state_q, state_d;
  pos_t       pos_q, pos_d;
  pos_t       tgt_q, tgt_d;
  logic [3:0] cnt_q, cnt_d;
  logic       frame_load;
  logic       frame_tc;

  logic       done_q, plot_q, busy_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;

  // The frame wait starts on the cycle after the last DRAW pixel.
  assign frame_load = (state_q == ST_DRAW) && (cnt_q == PIX_LAST);

  frame_ticker #(.FRAME_DIV(FRAME_DIV)) u_frame_ticker (
    .clock  (clock),
    .resetn (resetn),
    .load_i (frame_load),
    .tc_o   (frame_tc)
  );

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (leg_valid(travel)) begin
          pos_d   = leg_start(travel);
          tgt_d   = leg_end(travel);
          cnt_d   = '0;
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == PIX_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = '0;
        if (frame_tc) state_d = (pos_q == tgt_q) ? ST_DONE : ST_ERASE;
      end
      ST_ERASE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == PIX_LAST) state_d = ST_STEP;
      end
      ST_STEP: begin
`ifdef TRAVEL_DIAGONAL_EN
        pos_d.x = approach_x(pos_q.x, tgt_q.x);
        pos_d.y = approach_y(pos_q.y, tgt_q.y);
`else
        if (pos_q.x != tgt_q.x) pos_d.x = approach_x(pos_q.x, tgt_q.x);
        else                    pos_d.y = approach_y(pos_q.y, tgt_q.y);
`endif
        cnt_d   = '0;
        state_d = ST_DRAW;
      end
      ST_DONE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (travel == TRAVEL_NONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from next-state values so they line up with state_q.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      pos_q    <= STATION_S0;
      tgt_q    <= STATION_S0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      done_q   <= (state_d == ST_DONE);
      plot_q   <= (state_d == ST_DRAW) || (state_d == ST_ERASE);
      busy_q   <= (state_d != ST_IDLE);
      x_q      <= pos_d.x + {6'b0, cnt_d[1:0]};
      y_q      <= pos_d.y + {5'b0, cnt_d[3:2]};
      colour_q <= (state_d == ST_DRAW) ? SPRITE_COLOUR : 3'b000;
    end
  end

  assign done_travel = done_q;
  assign vga_plot    = plot_q;
  assign busy        = busy_q;
  assign vga_x       = x_q;
  assign vga_y       = y_q;
  assign vga_colour  = colour_q;

endmodule

// File: tb/tb_travel_animator.sv
// tb/tb_travel_animator.sv - scoreboard bench for travel_animator (FRAME_DIV=4)
module tb_travel_animator;

  localparam int         FRAME_DIV = 4;
  localparam logic [2:0] SPRITE    = 3'b110;
`ifdef TRAVEL_DIAGONAL_EN
  localparam int STEPS_101 = 44;
`else
  localparam int STEPS_101 = 76;
`endif

  logic       clock  = 1'b0;
  logic       resetn = 1'b1;
  logic [2:0] travel = 3'b000;
  logic       done_travel;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;

  travel_animator #(.FRAME_DIV(FRAME_DIV), .SPRITE_COLOUR(SPRITE)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .travel      (travel),
    .done_travel (done_travel),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int          checks   = 0;
  int          errors   = 0;
  int          draw_px  = 0;
  int          erase_px = 0;
  int          done_cnt = 0;
  logic [7:0]  last_x   = '0;
  logic [6:0]  last_y   = '0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic leg_of(input logic [2:0] code, output int sx, output int sy,
                        output int tx, output int ty);
    case (code)
      3'b001:  begin sx = 8;   sy = 56; tx = 44;  ty = 56;  end
      3'b010:  begin sx = 44;  sy = 56; tx = 80;  ty = 56;  end
      3'b011:  begin sx = 80;  sy = 56; tx = 116; ty = 56;  end
      default: begin sx = 116; sy = 56; tx = 148; ty = 100; end
    endcase
  endtask

  task automatic push_sprite(input int x, input int y, input logic [2:0] col);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back({8'(x + c), 7'(y + r), col});
  endtask

  task automatic push_leg(input logic [2:0] code);
    int px, py, tx, ty;
    leg_of(code, px, py, tx, ty);
    push_sprite(px, py, SPRITE);
    while (px != tx || py != ty) begin
      push_sprite(px, py, 3'b000);
`ifdef TRAVEL_DIAGONAL_EN
      if (px < tx) px++; else if (px > tx) px--;
      if (py < ty) py++; else if (py > ty) py--;
`else
      if (px != tx) px = (px < tx) ? px + 1 : px - 1;
      else          py = (py < ty) ? py + 1 : py - 1;
`endif
      push_sprite(px, py, SPRITE);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_travel !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_travel), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"},   32'(done_travel), 32'd0);
    check({tag, "_plot"},   32'(vga_plot),    32'd0);
    check({tag, "_busy"},   32'(busy),        32'd0);
    check({tag, "_x"},      32'(vga_x),       32'd0);
    check({tag, "_y"},      32'(vga_y),       32'd0);
    check({tag, "_colour"}, 32'(vga_colour),  32'd0);
  endtask

  task automatic hold_checks(input string tag);
    repeat (5) begin
      @(negedge clock);
      check({tag, "_hold_busy"}, 32'(busy),        32'd1);
      check({tag, "_hold_done"}, 32'(done_travel), 32'd0);
    end
  endtask

  // Scoreboard: every plotted pixel must match the next expected pixel.
  always @(negedge clock) begin
    if (vga_plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_plot", 32'({vga_x, vga_y, vga_colour}), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(mon_exp));
      end
      if (vga_colour == SPRITE) draw_px++;
      else                      erase_px++;
      last_x = vga_x;
      last_y = vga_y;
    end
    if (done_travel === 1'b1) done_cnt++;
  end

  initial begin
    int d0;
    int bad;
    int n;
    logic [2:0] bad_codes [3];
    bad_codes[0] = 3'b110;
    bad_codes[1] = 3'b100;
    bad_codes[2] = 3'b111;

    #3 resetn = 1'b0;
    #1 check_reset_outputs("reset_async");
    repeat (3) @(negedge clock);
    check_reset_outputs("reset_held");
    resetn = 1'b1;

    // Leg 001 with the code held through HOLD
    draw_px = 0; erase_px = 0; d0 = done_cnt;
    push_leg(3'b001);
    travel = 3'b001;
    wait_done("leg001", 5000);
    hold_checks("leg001");
    check("leg001_draws",  32'(draw_px),         32'(37 * 16));
    check("leg001_erases", 32'(erase_px),        32'(36 * 16));
    check("leg001_pulses", 32'(done_cnt - d0),   32'd1);
    check("leg001_queue",  32'(exp_q.size()),    32'd0);
    check("leg001_last_x", 32'(last_x),          32'd47);
    check("leg001_last_y", 32'(last_y),          32'd59);
    travel = 3'b000;
    @(negedge clock);
    check("leg001_release_busy", 32'(busy), 32'd0);

    // Undefined codes leave the block idle
    for (int i = 0; i < 3; i++) begin
      travel = bad_codes[i];
      bad = 0;
      repeat (100) begin
        @(negedge clock);
        if (busy !== 1'b0 || vga_plot !== 1'b0) bad++;
      end
      check("illegal_code_idle", 32'(bad), 32'd0);
    end
    travel = 3'b000;
    @(negedge clock);

    // Leg 010 interrupted by reset during an erase pass
    push_leg(3'b010);
    travel = 3'b010;
    n = 0;
    while (!(vga_plot === 1'b1 && vga_colour === 3'b000) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("leg010_erase_reached", 32'(vga_plot === 1'b1 && vga_colour === 3'b000), 32'd1);
    @(posedge clock);
    #2 resetn = 1'b0;
    travel = 3'b000;
    #1 check_reset_outputs("reset_mid_erase");
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;

    draw_px = 0; erase_px = 0; d0 = done_cnt;
    push_leg(3'b010);
    travel = 3'b010;
    wait_done("leg010", 5000);
    hold_checks("leg010");
    check("leg010_erases", 32'(erase_px),       32'(36 * 16));
    check("leg010_pulses", 32'(done_cnt - d0),  32'd1);
    check("leg010_queue",  32'(exp_q.size()),   32'd0);
    travel = 3'b000;
    @(negedge clock);
    check("leg010_release_busy", 32'(busy), 32'd0);

    // Leg 001 with the code changed to 011 mid-leg
    d0 = done_cnt;
    push_leg(3'b001);
    travel = 3'b001;
    repeat (200) @(negedge clock);
    travel = 3'b011;
    wait_done("switch", 5000);
    repeat (3) @(negedge clock);
    check("switch_pulses", 32'(done_cnt - d0), 32'd1);
    check("switch_queue",  32'(exp_q.size()),  32'd0);
    check("switch_last_x", 32'(last_x),        32'd47);
    check("switch_busy",   32'(busy),          32'd1);
    travel = 3'b000;
    @(negedge clock);
    check("switch_release_busy", 32'(busy), 32'd0);

    // Leg 101: the only leg with a y component
    draw_px = 0; erase_px = 0; d0 = done_cnt;
    push_leg(3'b101);
    travel = 3'b101;
    wait_done("leg101", 8000);
    repeat (2) @(negedge clock);
    check("leg101_steps",  32'(erase_px / 16),  32'(STEPS_101));
    check("leg101_draws",  32'(draw_px / 16),   32'(STEPS_101 + 1));
    check("leg101_last_x", 32'(last_x),         32'd151);
    check("leg101_last_y", 32'(last_y),         32'd103);
    check("leg101_queue",  32'(exp_q.size()),   32'd0);
    check("leg101_pulses", 32'(done_cnt - d0),  32'd1);
    travel = 3'b000;
    @(negedge clock);
    check("leg101_release_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/travel_animator.md
TRAVEL_ANIMATOR -- requirements
Module: travel_animator

Interface
REQ-001 Parameter FRAME_DIV, default 833333, is the clock cycles per animation frame (50 MHz / 60 Hz); legal range 1 to 2^20-1.
REQ-002 Parameter SPRITE_COLOUR, default 3'b110, is the RGB colour of the 4x4 transaction sprite.
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port travel, input, 3 bits: leg request from the animation controller; 001=S0->S1, 010=S1->S2, 011=S2->S3, 101=S3->S4, 000=none.
REQ-006 Port done_travel, output, 1 bit: one-cycle pulse when the requested leg is complete; feeds the animation controller.
REQ-007 Port vga_x, output, 8 bits: pixel x (0..159) to the VGA adapter.
REQ-008 Port vga_y, output, 7 bits: pixel y (0..119) to the VGA adapter.
REQ-009 Port vga_colour, output, 3 bits: pixel colour to the VGA adapter.
REQ-010 Port vga_plot, output, 1 bit: write strobe; the adapter writes the pixel in every cycle it is high.
REQ-011 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 Station table (x,y): S0=(8,56), S1=(44,56), S2=(80,56), S3=(116,56), S4=(148,100); the sprite covers pos..pos+3 in x and y.
REQ-013 FSM states: IDLE, DRAW, WAIT, ERASE, STEP, DONE, HOLD.
REQ-014 IDLE: on a valid code, load pos = leg start station and tgt = leg end station, then go to DRAW on the next cycle; codes 000, 100, 110 and 111 leave the block in IDLE.
REQ-015 DRAW: 16 cycles with vga_plot=1 and vga_colour=SPRITE_COLOUR; a 4-bit pixel counter scans row-major, vga_x = pos_x + cnt[1:0], vga_y = pos_y + cnt[3:2]; then go to WAIT.
REQ-016 WAIT: hold for FRAME_DIV cycles with vga_plot=0; then go to DONE if pos==tgt, else to ERASE.
REQ-017 ERASE: identical scan to DRAW but with vga_colour=3'b000; then go to STEP.
REQ-018 STEP: one cycle; move pos one pixel toward tgt (x first, y once x matches; or diagonal per REQ-026); then go to DRAW.
REQ-019 DONE: done_travel=1 for exactly one cycle; then go to HOLD.
REQ-020 HOLD: stay until travel==000, then go to IDLE; this prevents a stale code from re-triggering the leg.
REQ-021 Changes to travel while in DRAW, WAIT, ERASE or STEP are ignored; a leg always runs to completion.
REQ-022 Coordinate arithmetic is unsigned with no wrap; pos never passes tgt. A leg with pos==tgt at load (not reachable with this table) goes DRAW, WAIT, DONE.
REQ-023 vga_x, vga_y and vga_colour are don't-care whenever vga_plot=0; the bench checks them only when vga_plot=1.

Reset
REQ-024 While resetn=0, all outputs are asynchronously forced to the following values and held there: state=IDLE, done_travel=0, vga_plot=0, busy=0, vga_x=0, vga_y=0, vga_colour=0, pos=S0, all counters=0.
REQ-025 A reset mid-leg abandons the leg without an erase pass; the sprite pixels left on screen are acceptable.

Configuration
REQ-026 The macro TRAVEL_DIAGONAL_EN controls STEP: when defined, STEP moves x and y by one pixel each in the same cycle, each toward its own target, so leg length = max(|dx|,|dy|); when undefined, moves are x-then-y and leg length = |dx|+|dy|.

Structure
REQ-027 Shared package travel_pkg holds the travel code constants, the station coordinate table, SPRITE_W=4 and the FSM state encoding.
REQ-028 Sub-module frame_ticker, a down-counter loaded with FRAME_DIV-1, provides the WAIT terminal-count flag.

Verification (FRAME_DIV=4)
REQ-029 travel=001 held -> 37 DRAW bursts, 36 ERASE bursts and 36 STEPs, then one done_travel pulse; the final DRAW covers x 44..47, y 56..59, colour 110.
REQ-030 travel=101, macro undefined -> 76 STEPs, x reaches 148 before y changes, final pos=(148,100); with TRAVEL_DIAGONAL_EN -> 44 STEPs and the same final pos.
REQ-031 travel held at 010 for 5 cycles after done_travel -> no new DRAW and busy stays 1; travel=000 -> IDLE next cycle, busy=0.
REQ-032 travel=110 or 100 in IDLE -> vga_plot stays 0 and busy stays 0 for 100 cycles.
REQ-033 resetn pulsed low during ERASE of leg 010 -> outputs take reset values immediately; a new travel=010 restarts from S1 with a full initial DRAW.
REQ-034 travel switched 001->011 mid-leg -> leg 001 completes unchanged with exactly one done_travel pulse.
